// File: rtl/wptr_full_if.sv
// rtl/wptr_full_if.sv - write-side pointer/full-flag bus between FIFO write logic and its user
interface wptr_full_if #(
    parameter int ADDR_WIDTH = 3
);
    logic                  winc;
    logic                  ovf_clr;
    logic [ADDR_WIDTH:0]   rptr;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH:0]   wptr;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   wlevel;
    logic                  overflow;

    modport master (
        output winc, ovf_clr, rptr,
        input  wen, waddr, wptr, full, almost_full, wlevel, overflow
    );

    modport slave (
        input  winc, ovf_clr, rptr,
        output wen, waddr, wptr, full, almost_full, wlevel, overflow
    );
endinterface

// File: rtl/wptr_full.sv
// rtl/wptr_full.sv - dual-clock FIFO write pointer, full/almost-full, level and overflow logic
module wptr_full #(
    parameter int ADDR_WIDTH = 3,
    parameter int AF_THRESH  = 6
) (
    input  logic       wclk,
    input  logic       rst,
    wptr_full_if.slave bus
);
    localparam int A = ADDR_WIDTH;

    logic [A:0] wbin;
    logic [A:0] wptr_q;
    logic [A:0] rq1;
    logic [A:0] rq2;
    logic [A:0] wlevel_q;
    logic       full_q;
    logic       af_q;
    logic       ovf_q;

    logic [A:0] wbin_next;
    logic [A:0] wgray_next;
    logic [A:0] rbin_s;
    logic [A:0] level_next;
    logic       full_next;
    logic       wen_c;

    assign wen_c = bus.winc & ~full_q;

    always_comb begin
        wbin_next  = wbin + {{A{1'b0}}, wen_c};
        wgray_next = (wbin_next >> 1) ^ wbin_next;
        // Gray-to-binary of the synchronized read pointer, MSB down
        rbin_s     = '0;
        rbin_s[A]  = rq2[A];
        for (int i = A - 1; i >= 0; i--) begin
            rbin_s[i] = rbin_s[i+1] ^ rq2[i];
        end
        level_next = wbin_next - rbin_s;
        full_next  = (wgray_next == {~rq2[A:A-1], rq2[A-2:0]});
    end

    always_ff @(posedge wclk) begin
        if (rst) begin
            wbin     <= '0;
            wptr_q   <= '0;
            rq1      <= '0;
            rq2      <= '0;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            wlevel_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wbin     <= wbin_next;
            wptr_q   <= wgray_next;
            rq1      <= bus.rptr;
            rq2      <= rq1;
            full_q   <= full_next;
            af_q     <= (level_next >= (A+1)'(AF_THRESH));
            wlevel_q <= level_next;
            // a rejected write on the same edge as a clear keeps the flag set
            ovf_q    <= (ovf_q & ~bus.ovf_clr) | (bus.winc & full_q);
        end
    end

    assign bus.wen         = wen_c;
    assign bus.waddr       = wbin[A-1:0];
    assign bus.wptr        = wptr_q;
    assign bus.full        = full_q;
    assign bus.almost_full = af_q;
    assign bus.wlevel      = wlevel_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_wptr_full.sv
// tb/tb_wptr_full.sv - self-checking bench for wptr_full against a count-based occupancy model
module tb_wptr_full;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int MODV  = 16;
    localparam int AFT   = 6;

    logic wclk = 1'b0;
    logic rst;
    always #5 wclk = ~wclk;

    wptr_full_if #(.ADDR_WIDTH(AW)) bus ();

    wptr_full #(.ADDR_WIDTH(AW), .AF_THRESH(AFT)) dut (
        .wclk (wclk),
        .rst  (rst),
        .bus  (bus)
    );

    int nvec = 0;
    int nmis = 0;
    bit chk_en = 1'b0;

    // model: write count, read count seen through a two-stage delay, derived flags
    int m_w, m_s1, m_s2, m_level;
    bit m_full, m_af, m_ovf;
    int rd_cnt;

    function automatic logic [AW:0] gray(int b);
        logic [AW:0] v;
        v = b[AW:0];
        return v ^ (v >> 1);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(posedge wclk) begin : model
        bit acc;
        if (rst) begin
            m_w = 0; m_s1 = 0; m_s2 = 0; m_level = 0;
            m_full = 0; m_af = 0; m_ovf = 0;
        end else begin
            acc     = bus.winc && !m_full;
            m_ovf   = (m_ovf && !bus.ovf_clr) || (bus.winc && m_full);
            m_w     = (m_w + int'(acc)) % MODV;
            m_level = ((m_w - m_s2) % MODV + MODV) % MODV;
            m_full  = (m_level == DEPTH);
            m_af    = (m_level >= AFT);
            m_s2    = m_s1;
            m_s1    = rd_cnt % MODV;
        end
    end

    always @(negedge wclk) begin
        if (chk_en) begin
            chk("wptr",        32'(bus.wptr),        32'(gray(m_w)));
            chk("waddr",       32'(bus.waddr),       32'(m_w % DEPTH));
            chk("full",        32'(bus.full),        32'(m_full));
            chk("almost_full", 32'(bus.almost_full), 32'(m_af));
            chk("wlevel",      32'(bus.wlevel),      32'(m_level));
            chk("overflow",    32'(bus.overflow),    32'(m_ovf));
            chk("wen",         32'(bus.wen),         32'(bus.winc & !m_full));
        end
    end

    task automatic step(bit w, bit c, int r, bit rs);
        bus.winc    = w;
        bus.ovf_clr = c;
        rd_cnt      = r;
        bus.rptr    = gray(r);
        rst         = rs;
        @(posedge wclk);
        #1;
    endtask

    logic [3:0] seq [8];

    initial begin
        seq = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};
        rd_cnt = 0;

        step(0, 0, 0, 1);
        chk_en = 1'b1;
        chk("rst_wptr",   32'(bus.wptr),     0);
        chk("rst_wlevel", 32'(bus.wlevel),   0);
        chk("rst_full",   32'(bus.full),     0);
        chk("rst_ovf",    32'(bus.overflow), 0);

        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 0);
            chk("fill_wptr", 32'(bus.wptr), 32'(seq[i]));
            chk("fill_af",   32'(bus.almost_full), (i >= 5) ? 1 : 0);
            chk("fill_full", 32'(bus.full), (i == 7) ? 1 : 0);
        end
        chk("fill_level", 32'(bus.wlevel), 8);

        bus.winc = 1'b1;
        #1;
        chk("wen_when_full", 32'(bus.wen), 0);
        step(1, 0, 0, 0);
        chk("wf_wptr",  32'(bus.wptr),     12);
        chk("wf_waddr", 32'(bus.waddr),    0);
        chk("wf_ovf",   32'(bus.overflow), 1);
        step(0, 1, 0, 0);
        chk("ovf_clr", 32'(bus.overflow), 0);
        step(1, 0, 0, 0);
        chk("ovf_reset", 32'(bus.overflow), 1);
        step(1, 1, 0, 0);
        chk("ovf_set_wins", 32'(bus.overflow), 1);

        step(0, 0, 1, 0);
        chk("rel_full_e1", 32'(bus.full), 1);
        step(0, 0, 1, 0);
        chk("rel_full_e2", 32'(bus.full), 1);
        step(0, 0, 1, 0);
        chk("rel_full_e3",  32'(bus.full),   0);
        chk("rel_level_e3", 32'(bus.wlevel), 7);

        for (int i = 0; i < 3; i++) step(0, 0, 3, 0);
        chk("af_lvl5", 32'(bus.wlevel),      5);
        chk("af_off5", 32'(bus.almost_full), 0);
        step(1, 0, 3, 0);
        chk("af_on6", 32'(bus.almost_full), 1);
        step(0, 0, 4, 0);
        chk("af_rd_e1", 32'(bus.almost_full), 1);
        step(0, 0, 4, 0);
        chk("af_rd_e2", 32'(bus.almost_full), 1);
        step(0, 0, 4, 0);
        chk("af_rd_e3",  32'(bus.almost_full), 0);
        chk("af_lvl_e3", 32'(bus.wlevel),      5);

        step(1, 0, 0, 1);
        chk("mrst_wptr",  32'(bus.wptr),     0);
        chk("mrst_waddr", 32'(bus.waddr),    0);
        chk("mrst_level", 32'(bus.wlevel),   0);
        chk("mrst_full",  32'(bus.full),     0);
        chk("mrst_ovf",   32'(bus.overflow), 0);

        for (int n = 0; n < 20; n++) begin
            step(1, 0, n, 0);
            chk("wrap_full",     32'(bus.full), 0);
            chk("wrap_level_le3", 32'(bus.wlevel <= 3), 1);
            if (n == 14) chk("wrap_wptr15", 32'(bus.wptr), 8);
            if (n == 15) chk("wrap_wptr16", 32'(bus.wptr), 0);
        end

        for (int i = 0; i < 4; i++) step(0, 0, 20, 0);
        chk("drain_level", 32'(bus.wlevel), 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/wptr_full.md
# wptr_full

Write-side pointer and full-flag controller for the dual-clock FIFO. It is the write-domain counterpart of the read-pointer/empty logic. It holds the binary write address and publishes a registered Gray-coded write pointer to the read domain. It also synchronizes the read domain's Gray pointer internally and derives `full`, `almost_full`, a fill-level estimate and a sticky overflow flag, all in the write clock domain.

## Interface
- `ADDR_WIDTH`, 3: memory address width, ≥2. FIFO depth is 2^ADDR_WIDTH.
- `AF_THRESH`, 6: `almost_full` asserts when the level is ≥ this value. Range is 1..2^ADDR_WIDTH.

- `wclk`  in  1  write clock; the only clock in this block.
- `rst`  in  1  synchronous, active-high reset, sampled on `wclk` rising edge.
- `winc`  in  1  write request; a write is accepted when `winc & ~full`.
- `rptr`  in  ADDR_WIDTH+1  Gray read pointer from the read domain; asynchronous to `wclk`.
- `ovf_clr`  in  1  clears `overflow`.
- `wen`  out  1  memory write enable, combinational `winc & ~full`.
- `waddr`  out  ADDR_WIDTH  memory write address, equal to `wbin[ADDR_WIDTH-1:0]`.
- `wptr`  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the read domain.
- `full`  out  1  registered full flag.
- `almost_full`  out  1  registered; asserted when `wlevel` ≥ `AF_THRESH`.
- `wlevel`  out  ADDR_WIDTH+1  registered occupancy estimate, range 0..2^ADDR_WIDTH.
- `overflow`  out  1  sticky; set by a write attempt while full.

## Operation
- **Reset values** (when `rst` is high at an edge): `wbin`=0, `wptr`=0, `rq1`=0, `rq2`=0, `full`=0, `almost_full`=0, `wlevel`=0, `overflow`=0. Reset overrides every other input on the same edge.
- **Read-pointer synchronizer:** two flops, `rq1 <= rptr` and `rq2 <= rq1`. No other logic reads `rptr` directly.
- **Next binary pointer:** `wbin_next = wbin + (winc & ~full)`. Width is ADDR_WIDTH+1, modulo 2^(ADDR_WIDTH+1).
- **Next Gray pointer:** `wgray_next = (wbin_next >> 1) ^ wbin_next`.
- **Each edge:** `wbin <= wbin_next` and `wptr <= wgray_next`. The pointer changes by exactly one Gray bit per accepted write.
- **Full:** `full <= (wgray_next == {~rq2[A:A-1], rq2[A-2:0]})`, where A = ADDR_WIDTH.
- **Read binary:** `rbin_s[i] = ^rq2[A:i]` (Gray-to-binary conversion of the synchronized read pointer).
- **Level:** `wlevel <= wbin_next - rbin_s`, modulo 2^(A+1). The result is never above 2^A under legal operation.
- **Almost full:** `almost_full <= ((wbin_next - rbin_s) >= AF_THRESH)`.
- **Overflow:** `overflow <= (overflow & ~ovf_clr) | (winc & full)`. On the same edge, a set takes priority over a clear.
- **Write while full:** no pointer movement, `wen`=0, and the memory is untouched.
- **Wrap-around:** `wbin` wraps from 2^(A+1)-1 to 0. The Gray pointer wraps with a single-bit change (for A=3, 8 -> 0).
- The flags are pessimistic. `full` and `almost_full` may stay high for up to 3 `wclk` edges after the read side frees space. They never deassert early.

## Timing
- **Accepted write:** `waddr`, `wptr`, `full`, `wlevel` and `almost_full` all update on the edge where `winc & ~full` is sampled.
- **Filling:** after the 2^A-th unread write, `full`=1 immediately after that edge. A `winc` on the next cycle is rejected.
- **Read-pointer latency:** a change on `rptr` reaches `rq2` after 2 edges. It is reflected in `full`, `wlevel` and `almost_full` on the 3rd edge, and only once `wbin_next` is re-evaluated (every edge).
- **Simultaneous events:** an accepted write and a read-pointer update on the same edge are both accounted for. The level is computed from `wbin_next` and the current `rq2`.
- **Mid-operation reset:** all outputs return to their reset values on the next edge. The read domain must also be reset, because pointer consistency is not retained.
- **`wen`:** combinational with no register, valid in the same cycle as `winc`.

## Test plan
- **Reset and fill:** reset, hold `rptr`=0, pulse `winc` for 8 cycles (A=3) -> `wptr` runs 1,3,2,6,7,5,4,12; `full`=1 after the 8th edge; `wlevel`=8; `almost_full`=1 from the 6th edge.
- **Write while full:** `winc`=1 while `full` -> `wen`=0, `wptr` stays 12, `waddr` stays 0, `overflow`=1. Then `ovf_clr`=1 with `winc`=0 -> `overflow`=0 next edge. With `ovf_clr` and a rejected `winc` on the same edge -> `overflow` stays 1.
- **Full release latency:** while full, set `rptr`=1 -> `full` still 1 after 2 edges, 0 after the 3rd; `wlevel`=7.
- **Wrap-around:** write continuously with `rptr` tracking `wptr` delayed by 2 -> `wbin` passes 15->0, `wptr` passes 8->0, `full` never asserts, `wlevel` stays ≤3.
- **Almost-full boundary:** with `AF_THRESH`=6, level 5 plus one write -> `almost_full` 0->1 on that edge. Advance `rptr` by one -> `almost_full` clears 3 edges later.
- **Reset mid-operation:** assert `rst` for one cycle with level 5 and `overflow`=1 -> next edge shows `wptr`=0, `waddr`=0, `wlevel`=0, `full`=0, `overflow`=0.
